// File: rtl/cbfp_block_norm_pkg.sv
// Shared types and arithmetic helpers for the CBFP normaliser.
package cbfp_pkg;

   localparam int CBFP_DEF_IN_W  = 23;
   localparam int CBFP_DEF_IDX_W = $clog2(CBFP_DEF_IN_W);

   typedef enum logic {
      CBFP_BLOCK = 1'b0,
      CBFP_LANE  = 1'b1
   } cbfp_mode_e;

   // Redundant sign bits below the MSB of a width-bit value (0 and -1 give width-1).
   function automatic int lsb_count(input longint value, input int width);
      int   cnt;
      logic run;
      cnt = 0;
      run = 1'b1;
      for (int i = 62; i >= 0; i--) begin
         if (i < width - 1) begin
            if (run && (value[i] == value[width-1])) cnt++;
            else run = 1'b0;
         end
      end
      return cnt;
   endfunction

   // Round half up and drop in_w-out_w LSBs, then clamp to the out_w signed range.
   function automatic longint sat_round(input longint value, input int in_w, input int out_w);
      longint r, hi, lo;
      hi = (longint'(1) <<< (out_w - 1)) - 1;
      lo = -(longint'(1) <<< (out_w - 1));
      r  = (value + (longint'(1) <<< (in_w - out_w - 1))) >>> (in_w - out_w);
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/cbfp_block_norm_if.sv
// Beat-level stream bundle between the butterfly stage, the normaliser and its consumer.
interface cbfp_block_norm_if #(
   parameter int N     = 16,
   parameter int IN_W  = 23,
   parameter int OUT_W = 11,
   parameter int IDX_W = 5
);
   logic                    valid_in;
   logic signed [IN_W-1:0]  din_i [N];
   logic signed [IN_W-1:0]  din_q [N];
   logic                    valid_out;
   logic                    sop_out;
   logic signed [OUT_W-1:0] dout_i [N];
   logic signed [OUT_W-1:0] dout_q [N];
   logic [IDX_W-1:0]        index_out [N];

   modport master (
      output valid_in, din_i, din_q,
      input  valid_out, sop_out, dout_i, dout_q, index_out
   );

   modport slave (
      input  valid_in, din_i, din_q,
      output valid_out, sop_out, dout_i, dout_q, index_out
   );
endinterface

// File: rtl/cbfp_block_norm_lsb_cnt.sv
// Combinational leading-sign counter for one W-bit signed sample.
module cbfp_lsb_cnt
   import cbfp_pkg::*;
#(
   parameter int W     = 23,
   parameter int IDX_W = $clog2(W)
) (
   input  logic signed [W-1:0] value,
   output logic [IDX_W-1:0]    count
);

   // Count sign-bit copies directly below the MSB
   always_comb count = IDX_W'(lsb_count(longint'(value), W));

endmodule

// File: rtl/cbfp_block_norm.sv
// Convergent block-floating-point normaliser: collects a block into one bank while
// draining the previous block from the other, shifted by its per-block or per-lane exponent.
//
// drain state | meaning
// DR_IDLE     | no completed block pending, read stage idle
// DR_RUN      | reading beat drain_cnt of bank drain_bank into the read stage
module cbfp_block_norm
   import cbfp_pkg::*;
#(
   parameter int N         = 16,
   parameter int IN_W      = 23,
   parameter int OUT_W     = 11,
   parameter int BLK_BEATS = 4,
   parameter int IDX_W     = $clog2(IN_W)
) (
   input  logic clk,
   input  logic rst,
   input  logic cfg_mode,
   input  logic flush,
   cbfp_block_norm_if.slave bus
);

   localparam int               CNT_W     = $clog2(BLK_BEATS);
   localparam logic [IDX_W-1:0] LSB_MAX   = IDX_W'(IN_W - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_BEATS - 1);

   typedef enum logic {DR_IDLE, DR_RUN} drain_state_e;

   logic signed [IN_W-1:0]  mem_i [2][BLK_BEATS][N];
   logic signed [IN_W-1:0]  mem_q [2][BLK_BEATS][N];
   logic [IDX_W-1:0]        shift_bank [2][N];
   logic [IDX_W-1:0]        lane_min [N];
   logic [IDX_W-1:0]        lsb_i [N];
   logic [IDX_W-1:0]        lsb_q [N];
   logic [IDX_W-1:0]        cur_min [N];
   logic [IDX_W-1:0]        shift_next [N];
   logic [IDX_W-1:0]        blk_min;
   logic [CNT_W-1:0]        beat_cnt;
   logic                    wr_bank;
   cbfp_mode_e              mode_lat;
   logic                    take_beat;
   logic                    blk_end;

   drain_state_e            drain_state;
   logic [CNT_W-1:0]        drain_cnt;
   logic                    drain_bank;

   logic                    rd_valid;
   logic                    rd_sop;
   logic signed [IN_W-1:0]  rd_i [N];
   logic signed [IN_W-1:0]  rd_q [N];
   logic [IDX_W-1:0]        rd_sh [N];
   logic signed [IN_W-1:0]  sh_i [N];
   logic signed [IN_W-1:0]  sh_q [N];
   logic signed [OUT_W-1:0] nrm_i [N];
   logic signed [OUT_W-1:0] nrm_q [N];

   // flush wins over a beat presented in the same cycle
   assign take_beat = bus.valid_in && !flush;
   assign blk_end   = take_beat && (beat_cnt == LAST_BEAT);

   for (genvar k = 0; k < N; k++) begin : g_lsb
      cbfp_lsb_cnt #(.W(IN_W), .IDX_W(IDX_W)) u_lsb_i (.value(bus.din_i[k]), .count(lsb_i[k]));
      cbfp_lsb_cnt #(.W(IN_W), .IDX_W(IDX_W)) u_lsb_q (.value(bus.din_q[k]), .count(lsb_q[k]));
   end

   // Fold the incoming beat into the running minimums and form the shift vector
   always_comb begin
      blk_min = LSB_MAX;
      for (int k = 0; k < N; k++) begin
         cur_min[k] = lane_min[k];
         if (lsb_i[k] < cur_min[k]) cur_min[k] = lsb_i[k];
         if (lsb_q[k] < cur_min[k]) cur_min[k] = lsb_q[k];
         if (cur_min[k] < blk_min)  blk_min    = cur_min[k];
      end
      for (int k = 0; k < N; k++) begin
         shift_next[k] = (mode_lat == CBFP_LANE) ? cur_min[k] : blk_min;
      end
   end

   // Bank write: the collecting bank takes each accepted beat at address beat_cnt
   always_ff @(posedge clk) begin
      if (!rst && take_beat) begin
         for (int k = 0; k < N; k++) begin
            mem_i[wr_bank][beat_cnt][k] <= bus.din_i[k];
            mem_q[wr_bank][beat_cnt][k] <= bus.din_q[k];
         end
      end
   end

   // Collect side: beat counter, running minimums, mode latch and bank swap
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         wr_bank  <= 1'b0;
         mode_lat <= CBFP_BLOCK;
         lane_min <= '{default: LSB_MAX};
      end else if (flush) begin
         beat_cnt <= '0;
         lane_min <= '{default: LSB_MAX};
      end else if (bus.valid_in) begin
         if (beat_cnt == '0) mode_lat <= cbfp_mode_e'(cfg_mode);
         if (blk_end) begin
            for (int k = 0; k < N; k++) shift_bank[wr_bank][k] <= shift_next[k];
            wr_bank  <= ~wr_bank;
            beat_cnt <= '0;
            lane_min <= '{default: LSB_MAX};
         end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            lane_min <= cur_min;
         end
      end
   end

   // Shift, round and saturate the beat held in the read stage
   always_comb begin
      for (int k = 0; k < N; k++) begin
         sh_i[k]  = rd_i[k] <<< rd_sh[k];
         sh_q[k]  = rd_q[k] <<< rd_sh[k];
         nrm_i[k] = OUT_W'(sat_round(longint'(sh_i[k]), IN_W, OUT_W));
         nrm_q[k] = OUT_W'(sat_round(longint'(sh_q[k]), IN_W, OUT_W));
      end
   end

   // Drain sequencer, synchronous bank read stage and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         drain_state   <= DR_IDLE;
         drain_cnt     <= '0;
         drain_bank    <= 1'b0;
         rd_valid      <= 1'b0;
         rd_sop        <= 1'b0;
         bus.valid_out <= 1'b0;
         bus.sop_out   <= 1'b0;
         for (int k = 0; k < N; k++) begin
            bus.dout_i[k]    <= '0;
            bus.dout_q[k]    <= '0;
            bus.index_out[k] <= '0;
         end
      end else begin
         rd_valid <= 1'b0;
         if (drain_state == DR_RUN) begin
            rd_valid <= 1'b1;
            rd_sop   <= (drain_cnt == '0);
            for (int k = 0; k < N; k++) begin
               rd_i[k]  <= mem_i[drain_bank][drain_cnt][k];
               rd_q[k]  <= mem_q[drain_bank][drain_cnt][k];
               rd_sh[k] <= shift_bank[drain_bank][k];
            end
            if (drain_cnt == LAST_BEAT) drain_state <= DR_IDLE;
            else                        drain_cnt   <= drain_cnt + CNT_W'(1);
         end
         // a new block can only complete as the previous drain reads its last beat
         if (blk_end) begin
            drain_state <= DR_RUN;
            drain_cnt   <= '0;
            drain_bank  <= wr_bank;
         end
         bus.valid_out <= rd_valid;
         if (rd_valid) begin
            bus.sop_out <= rd_sop;
            for (int k = 0; k < N; k++) begin
               bus.dout_i[k]    <= nrm_i[k];
               bus.dout_q[k]    <= nrm_q[k];
               bus.index_out[k] <= rd_sh[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Self-checking bench for cbfp_block_norm: constant vectors, hand sequences and a
// randomized run scored against an arithmetic reference model.
module tb_cbfp_block_norm;

   localparam int N     = 16;
   localparam int IN_W  = 23;
   localparam int OUT_W = 11;
   localparam int BLK   = 4;
   localparam int IDX_W = $clog2(IN_W);

   typedef logic signed [IN_W-1:0] beat_t [N];
   typedef struct {
      logic sop;
      int   oi  [N];
      int   oq  [N];
      int   idx [N];
   } exp_t;
   typedef struct {
      logic mode;
      int   l0;
      int   oth;
      int   qv;
      int   e_l0;
      int   e_oth;
      int   x_l0;
      int   x_oth;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic cfg_mode;
   logic flush;

   cbfp_block_norm_if #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

   cbfp_block_norm #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .BLK_BEATS(BLK), .IDX_W(IDX_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_mode (cfg_mode),
      .flush    (flush),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   exp_t   exp_q [$];
   exp_t   mon_e;
   beat_t  pb_i [BLK];
   beat_t  pb_q [BLK];
   int     pb_n = 0;
   logic   pb_mode = 1'b0;
   int     out_beats = 0;
   int     run_len = 0;
   int     max_run = 0;
   beat_t  zero_b;
   beat_t  bi, bq;
   vec_t   vecs [8];

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_lsb(input longint x);
      longint lo, hi;
      int     n;
      lo = -(longint'(1) << (IN_W - 1));
      hi = (longint'(1) << (IN_W - 1)) - 1;
      n  = 0;
      while (n < IN_W - 1 && x * (longint'(1) << (n + 1)) >= lo
                          && x * (longint'(1) << (n + 1)) <= hi) n++;
      return n;
   endfunction

   function automatic int ref_out(input longint x, input int sh);
      longint num, d, q, lim;
      d   = longint'(1) << (IN_W - OUT_W);
      num = x * (longint'(1) << sh) + d / 2;
      q   = num / d;
      if (num < 0 && (num % d) != 0) q = q - 1;
      lim = longint'(1) << (OUT_W - 1);
      if (q > lim - 1) q = lim - 1;
      if (q < -lim)    q = -lim;
      return int'(q);
   endfunction

   task automatic model_block();
      int   lm [N];
      int   bm, sh, v;
      exp_t e;
      bm = IN_W - 1;
      for (int k = 0; k < N; k++) begin
         lm[k] = IN_W - 1;
         for (int b = 0; b < BLK; b++) begin
            v = ref_lsb(longint'(pb_i[b][k])); if (v < lm[k]) lm[k] = v;
            v = ref_lsb(longint'(pb_q[b][k])); if (v < lm[k]) lm[k] = v;
         end
         if (lm[k] < bm) bm = lm[k];
      end
      for (int b = 0; b < BLK; b++) begin
         e.sop = (b == 0);
         for (int k = 0; k < N; k++) begin
            sh       = pb_mode ? lm[k] : bm;
            e.idx[k] = sh;
            e.oi[k]  = ref_out(longint'(pb_i[b][k]), sh);
            e.oq[k]  = ref_out(longint'(pb_q[b][k]), sh);
         end
         exp_q.push_back(e);
      end
   endtask

   // One clock cycle of stimulus, mirrored into the reference model.
   task automatic cycle(input logic v, input logic fl, input logic md, input beat_t i_b, input beat_t q_b);
      bus.valid_in = v;
      flush        = fl;
      cfg_mode     = md;
      for (int k = 0; k < N; k++) begin
         bus.din_i[k] = i_b[k];
         bus.din_q[k] = q_b[k];
      end
      if (fl) pb_n = 0;
      else if (v) begin
         if (pb_n == 0) pb_mode = md;
         pb_i[pb_n] = i_b;
         pb_q[pb_n] = q_b;
         pb_n++;
         if (pb_n == BLK) begin
            model_block();
            pb_n = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, 1'b0, zero_b, zero_b);
   endtask

   function automatic logic signed [IN_W-1:0] rnd_val();
      int                     w;
      logic signed [IN_W-1:0] v;
      w = $urandom_range(IN_W, 1);
      v = IN_W'($urandom);
      return (v <<< (IN_W - w)) >>> (IN_W - w);
   endfunction

   task automatic rnd_beat();
      for (int k = 0; k < N; k++) begin
         bi[k] = rnd_val();
         bq[k] = rnd_val();
      end
   endtask

   initial begin
      int  b0;
      bit  ok;
      for (int k = 0; k < N; k++) zero_b[k] = '0;
      rst = 1'b1; flush = 1'b0; cfg_mode = 1'b0; bus.valid_in = 1'b0;
      for (int k = 0; k < N; k++) begin bus.din_i[k] = '0; bus.din_q[k] = '0; end

      fork
         forever begin
            @(negedge clk); #1;
            if (rst) run_len = 0;
            else if (bus.valid_out) begin
               out_beats++;
               run_len++;
               if (run_len > max_run) max_run = run_len;
               if (exp_q.size() == 0) check(1'b0, "unexpected_beat", 1, 0);
               else begin
                  mon_e = exp_q.pop_front();
                  ok = (bus.sop_out == mon_e.sop);
                  for (int k = 0; k < N; k++) begin
                     if (int'(bus.dout_i[k]) != mon_e.oi[k] || int'(bus.dout_q[k]) != mon_e.oq[k]
                         || int'(bus.index_out[k]) != mon_e.idx[k]) begin
                        if (ok) $display("FAIL beat lane %0d: got i=%0d q=%0d idx=%0d expected i=%0d q=%0d idx=%0d",
                                         k, bus.dout_i[k], bus.dout_q[k], bus.index_out[k],
                                         mon_e.oi[k], mon_e.oq[k], mon_e.idx[k]);
                        ok = 1'b0;
                     end
                  end
                  check(ok, "beat_vs_model", bus.sop_out, mon_e.sop);
               end
            end else run_len = 0;
         end
      join_none

      // reset state
      @(negedge clk); @(negedge clk);
      ok = !bus.valid_out && !bus.sop_out;
      for (int k = 0; k < N; k++)
         if (bus.dout_i[k] != 0 || bus.dout_q[k] != 0 || bus.index_out[k] != 0) ok = 1'b0;
      check(ok, "reset_outputs", bus.valid_out, 0);
      rst = 1'b0;
      idle(2);

      // constant vectors: lane 0 and the other lanes carry different values
      vecs[0] = '{1'b0,        1,    1, 0,   512,  512, 21, 21};
      vecs[1] = '{1'b0,       -1,    1, 0,  -512,  512, 21, 21};
      vecs[2] = '{1'b1,       -1,    1, 0, -1024,  512, 22, 21};
      vecs[3] = '{1'b0,  4194303,    0, 0,  1023,    0,  0,  0};
      vecs[4] = '{1'b1,  4194303,    0, 0,  1023,    0,  0, 22};
      vecs[5] = '{1'b0, -4194304,    5, 0, -1024,    0,  0,  0};
      vecs[6] = '{1'b1,       -3, 1000, 0,  -768, 1000, 20, 12};
      vecs[7] = '{1'b0,       -3, 1000, 0,    -3, 1000, 12, 12};
      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < N; k++) begin
            bi[k] = (k == 0) ? IN_W'(vecs[v].l0) : IN_W'(vecs[v].oth);
            bq[k] = IN_W'(vecs[v].qv);
         end
         for (int b = 0; b < BLK; b++) cycle(1'b1, 1'b0, vecs[v].mode, bi, bq);
         check(!bus.valid_out, "latency_cycle0", bus.valid_out, 0);
         idle(1);
         check(!bus.valid_out, "latency_cycle1", bus.valid_out, 0);
         idle(1);
         check(bus.valid_out && bus.sop_out, "first_beat_sop", bus.sop_out, 1);
         check(int'(bus.dout_i[0]) == vecs[v].e_l0, "vec_lane0_i", bus.dout_i[0], vecs[v].e_l0);
         check(int'(bus.dout_i[1]) == vecs[v].e_oth, "vec_lane1_i", bus.dout_i[1], vecs[v].e_oth);
         check(int'(bus.index_out[0]) == vecs[v].x_l0, "vec_lane0_idx", bus.index_out[0], vecs[v].x_l0);
         check(int'(bus.index_out[1]) == vecs[v].x_oth, "vec_lane1_idx", bus.index_out[1], vecs[v].x_oth);
         idle(3);
         check(bus.valid_out && !bus.sop_out, "last_beat_no_sop", bus.sop_out, 0);
         idle(1);
         check(!bus.valid_out, "drain_length", bus.valid_out, 0);
      end

      // cfg_mode changes after the first beat are ignored
      for (int k = 0; k < N; k++) begin bi[k] = (k == 0) ? -23'sd1 : 23'sd1; bq[k] = '0; end
      cycle(1'b1, 1'b0, 1'b1, bi, bq);
      for (int b = 1; b < BLK; b++) cycle(1'b1, 1'b0, 1'b0, bi, bq);
      idle(2);
      check(int'(bus.index_out[0]) == 22, "mode_latched_idx", bus.index_out[0], 22);
      idle(4);

      // back-to-back blocks, then blocks with random gaps
      max_run = 0;
      for (int b = 0; b < 2 * BLK; b++) begin rnd_beat(); cycle(1'b1, 1'b0, 1'(b / BLK), bi, bq); end
      idle(8);
      check(max_run == 2 * BLK, "back_to_back_run", max_run, 2 * BLK);
      check(exp_q.size() == 0, "back_to_back_drained", exp_q.size(), 0);
      b0 = out_beats;
      for (int b = 0; b < 3 * BLK; b++) begin
         idle($urandom_range(2, 0));
         rnd_beat();
         cycle(1'b1, 1'b0, 1'($urandom_range(1, 0)), bi, bq);
      end
      idle(8);
      check(out_beats - b0 == 3 * BLK, "gapped_beats", out_beats - b0, 3 * BLK);

      // flush after two beats (flush also discards a same-cycle beat), then a fresh block
      b0 = out_beats;
      for (int b = 0; b < 2; b++) begin rnd_beat(); cycle(1'b1, 1'b0, 1'b0, bi, bq); end
      rnd_beat(); cycle(1'b1, 1'b1, 1'b0, bi, bq);
      for (int b = 0; b < BLK; b++) begin rnd_beat(); cycle(1'b1, 1'b0, 1'b0, bi, bq); end
      idle(8);
      check(out_beats - b0 == BLK, "flush_partial_beats", out_beats - b0, BLK);
      // flush during drain leaves that drain intact
      b0 = out_beats;
      for (int b = 0; b < BLK; b++) begin rnd_beat(); cycle(1'b1, 1'b0, 1'b1, bi, bq); end
      idle(2);
      cycle(1'b0, 1'b1, 1'b0, zero_b, zero_b);
      idle(6);
      check(out_beats - b0 == BLK, "flush_in_drain_beats", out_beats - b0, BLK);
      check(exp_q.size() == 0, "flush_drained", exp_q.size(), 0);

      // reset in the middle of a drain
      for (int b = 0; b < BLK; b++) begin rnd_beat(); cycle(1'b1, 1'b0, 1'b0, bi, bq); end
      idle(3);
      rst = 1'b1; pb_n = 0; exp_q.delete();
      @(negedge clk);
      ok = !bus.valid_out && !bus.sop_out;
      for (int k = 0; k < N; k++)
         if (bus.dout_i[k] != 0 || bus.dout_q[k] != 0 || bus.index_out[k] != 0) ok = 1'b0;
      check(ok, "reset_mid_drain_zero", bus.valid_out, 0);
      @(negedge clk);
      rst = 1'b0;
      b0 = out_beats;
      idle(8);
      check(out_beats == b0, "no_output_after_reset", out_beats - b0, 0);
      for (int b = 0; b < BLK; b++) begin rnd_beat(); cycle(1'b1, 1'b0, 1'b1, bi, bq); end
      idle(8);
      check(out_beats - b0 == BLK, "block_after_reset", out_beats - b0, BLK);

      // randomized traffic with gaps, mode changes and occasional flush
      for (int c = 0; c < 400; c++) begin
         rnd_beat();
         cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(15, 0) == 0),
               1'($urandom_range(1, 0)), bi, bq);
      end
      idle(10);
      check(exp_q.size() == 0, "random_all_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
